// File: rtl/sr_alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states,
// iteration kind for the shared shift-add / restoring-divide datapath.
package sr_alu_pkg;

   // Operation codes carried on the 4-bit oper input.
   typedef enum logic [3:0] {
      ADD   = 4'd0,
      OR    = 4'd1,
      SRL   = 4'd2,
      SLTU  = 4'd3,
      SUB   = 4'd4,
      MUL   = 4'd5,
      MULHU = 4'd6,
      DIVU  = 4'd7,
      REMU  = 4'd8
   } alu_op_t;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Which recurrence the shared iteration step performs.
   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_kind_t;

   // True for ops that run through the WIDTH-cycle iterative datapath.
   function automatic logic is_iterative(input alu_op_t op);
      return (op == MUL) || (op == MULHU) || (op == DIVU) || (op == REMU);
   endfunction

   // Iterative ops whose answer sits in the upper half of the accumulator.
   function automatic logic takes_high_half(input alu_op_t op);
      return (op == MULHU) || (op == REMU);
   endfunction

endpackage

// File: rtl/sr_alu_iter_step.sv
// One radix-2 iteration of either the shift-add multiplier or the
// restoring divider, operating on the shared 2*WIDTH accumulator.
//
// Multiply layout: acc = {partial_product_high, multiplier_remaining}.
//   Each step adds the multiplicand to the high half when the current
//   multiplier LSB is set, then shifts the whole thing right by one
//   (carry goes into the top bit). After WIDTH steps acc = A*B.
//
// Divide layout: acc = {partial_remainder, dividend_remaining/quotient}.
//   Each step shifts left by one, trial-subtracts the divisor from the
//   remainder and shifts in a 1 when the subtraction does not borrow.
//   After WIDTH steps acc = {A%B, A/B}. With B=0 every trial succeeds,
//   so the quotient ends all-ones and the remainder ends equal to A,
//   which is exactly the RISC-V divide-by-zero result.
module sr_alu_iter_step
   import sr_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  step_kind_t         kind,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_trial;

   assign acc_hi = acc[2*WIDTH-1:WIDTH];
   assign acc_lo = acc[WIDTH-1:0];

   // Both candidate recurrences are formed, then the op kind selects one.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {WIDTH{1'b0}})};
      rem_shift = {acc_hi, acc_lo[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, operand};
      acc_nxt   = {mul_sum, acc_lo[WIDTH-1:1]};
      if (kind == STEP_DIV) begin
         if (!rem_trial[WIDTH]) begin
            acc_nxt = {rem_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/sr_alu_seq.sv
// Sequential ALU with a valid/ready request side and a valid/ready
// result side. Simple ops finish on the accepting edge; multiply and
// divide run WIDTH iterations through one shared datapath.
module sr_alu_seq
   import sr_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [3:0]       oper,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   state_t             state_reg;
   alu_op_t            op_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   opd_reg;
   logic [SHW-1:0]     cnt_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               zero_reg;
   logic               out_valid_reg;

   alu_op_t            op_in;
   logic               accept;
   logic [WIDTH-1:0]   simple_res;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   iter_res;
   step_kind_t         step_kind;

   assign op_in     = alu_op_t'(oper);
   assign in_ready  = (state_reg == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign zero      = zero_reg;

   // Single-cycle ops evaluated straight from the request; unknown codes add.
   always_comb begin
      simple_res = srcA + srcB;
      case (op_in)
         SUB:     simple_res = srcA - srcB;
         OR:      simple_res = srcA | srcB;
         SRL:     simple_res = srcA >> srcB[SHW-1:0];
         SLTU:    simple_res = (srcA < srcB) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
         default: simple_res = srcA + srcB;
      endcase
   end

   // Kind of iteration and final half selection for the latched op.
   always_comb begin
      step_kind = ((op_reg == DIVU) || (op_reg == REMU)) ? STEP_DIV : STEP_MUL;
      iter_res  = takes_high_half(op_reg) ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
   end

   sr_alu_iter_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc     (acc_reg),
      .operand (opd_reg),
      .kind    (step_kind),
      .acc_nxt (acc_nxt)
   );

   // Control FSM and all datapath registers; outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         op_reg        <= ADD;
         acc_reg       <= '0;
         opd_reg       <= '0;
         cnt_reg       <= '0;
         result_reg    <= '0;
         zero_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (is_iterative(op_in)) begin
                     // Both recurrences start from {0, A}; B is the step operand.
                     state_reg <= BUSY;
                     op_reg    <= op_in;
                     opd_reg   <= srcB;
                     acc_reg   <= {{WIDTH{1'b0}}, srcA};
                     cnt_reg   <= '0;
                  end else begin
                     state_reg     <= DONE;
                     op_reg        <= op_in;
                     result_reg    <= simple_res;
                     zero_reg      <= (simple_res == '0);
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            BUSY: begin
               acc_reg <= acc_nxt;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_ITER) begin
                  // The flag is taken from the finished value, never a partial one.
                  state_reg     <= DONE;
                  cnt_reg       <= '0;
                  result_reg    <= iter_res;
                  zero_reg      <= (iter_res == '0);
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_alu_seq.sv
// Bench for sr_alu_seq: a 32-bit instance driven with directed cases and
// an 8-bit instance driven with random back-to-back requests. Expected
// responses are queued at issue time and checked by a separate monitor.
module tb_sr_alu_seq;
   import sr_alu_pkg::*;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc_cyc;
      logic [3:0]  op;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic [3:0]  oper = '0;
   logic        in_valid32 = 1'b0;
   logic        in_valid8 = 1'b0;
   logic        out_ready32 = 1'b1;
   logic        out_ready8 = 1'b1;
   wire  [1:0]  in_ready;
   wire  [1:0]  out_valid;
   wire  [1:0]  zero;
   wire  [31:0] res32;
   wire  [7:0]  res8;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   rand_ready = 1'b0;
   bit   seen [2];
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sr_alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready[0]),
      .srcA(srcA), .srcB(srcB), .oper(oper), .out_valid(out_valid[0]),
      .out_ready(out_ready32), .result(res32), .zero(zero[0])
   );

   sr_alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready[1]),
      .srcA(srcA[7:0]), .srcB(srcB[7:0]), .oper(oper), .out_valid(out_valid[1]),
      .out_ready(out_ready8), .result(res8), .zero(zero[1])
   );

   // Reference: plain arithmetic on masked 64-bit values.
   function automatic logic [63:0] ref_calc(input int w, input logic [3:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] m, a, b, p;
      m = (64'd1 << w) - 64'd1;
      a = a_in & m;
      b = b_in & m;
      p = a * b;
      case (op)
         4'd1:    return a | b;
         4'd2:    return a >> (b % w);
         4'd3:    return (a < b) ? 64'd1 : 64'd0;
         4'd4:    return (a - b) & m;
         4'd5:    return p & m;
         4'd6:    return (p >> w) & m;
         4'd7:    return (b == 0) ? m : a / b;
         4'd8:    return (b == 0) ? a : a % b;
         default: return (a + b) & m;
      endcase
   endfunction

   function automatic int ref_lat(input int w, input logic [3:0] op);
      return (op >= 4'd5 && op <= 4'd8) ? w + 1 : 1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Must be called just after a falling edge; returns just after the
   // falling edge that follows the accepting rising edge.
   task automatic send(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int   guard;
      exp_t e;
      guard = 0;
      srcA = a;
      srcB = b;
      oper = op;
      if (d == 0) in_valid32 = 1'b1; else in_valid8 = 1'b1;
      while (!in_ready[d] && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout dut%0d: actual in_ready=0 required in_ready=1", d);
      end else begin
         e.op      = op;
         e.res     = ref_calc((d == 0) ? 32 : 8, op, {32'd0, a}, {32'd0, b});
         e.lat     = ref_lat((d == 0) ? 32 : 8, op);
         e.acc_cyc = cyc + 1;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         @(negedge clk);
      end
      in_valid32 = 1'b0;
      in_valid8  = 1'b0;
   endtask

   // Monitor: on each rising out_valid, pop the oldest expectation and compare.
   initial begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && !seen[d]) begin
               if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_out_valid dut%0d: actual out_valid=1 required 0 (nothing pending)", d);
               end else begin
                  exp_t        e;
                  logic [63:0] act;
                  if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                  act = (d == 0) ? {32'd0, res32} : {56'd0, res8};
                  chk($sformatf("result_dut%0d_op%0d", d, e.op), act, e.res);
                  chk($sformatf("zero_dut%0d_op%0d", d, e.op), {63'd0, zero[d]}, {63'd0, (e.res == 64'd0)});
                  chk($sformatf("latency_dut%0d_op%0d", d, e.op), 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                  $display("txn dut%0d op=%0d result=%0h expected=%0h latency=%0d", d, e.op, act, e.res, cyc - e.acc_cyc + 1);
               end
            end
            seen[d] = out_valid[d];
         end
      end
   end

   // Consumer back-pressure for the 8-bit instance, changed away from sampling.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready8 = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid[0]}, 64'd0);
      chk("rst_result", {32'd0, res32}, 64'd0);
      chk("rst_zero", {63'd0, zero[0]}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {63'd0, in_ready[0]}, 64'd1);

      // Directed 32-bit cases.
      send(0, ADD,   32'hFFFF_FFFF, 32'd1);
      send(0, MUL,   32'h0001_0000, 32'h0001_0000);
      send(0, MULHU, 32'h0001_0000, 32'h0001_0000);
      send(0, DIVU,  32'd100, 32'd7);
      send(0, REMU,  32'd100, 32'd7);
      send(0, DIVU,  32'd5, 32'd0);
      send(0, REMU,  32'd5, 32'd0);
      send(0, SUB,   32'd3, 32'd5);
      send(0, SRL,   32'h8000_0000, 32'd31);

      // Result held under back-pressure.
      send(0, DIVU, 32'd1000, 32'd3);
      out_ready32 = 1'b0;
      g = 0;
      while (!out_valid[0] && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) begin
         checks++;
         errors++;
         $display("FAIL hold_wait: actual out_valid=0 required out_valid=1");
      end
      repeat (10) begin
         @(negedge clk);
         chk("hold_result", {32'd0, res32}, 64'd333);
         chk("hold_zero", {63'd0, zero[0]}, 64'd0);
         chk("hold_out_valid", {63'd0, out_valid[0]}, 64'd1);
         chk("hold_in_ready", {63'd0, in_ready[0]}, 64'd0);
      end
      out_ready32 = 1'b1;
      @(negedge clk);
      chk("in_ready_after_handshake", {63'd0, in_ready[0]}, 64'd1);
      chk("out_valid_after_handshake", {63'd0, out_valid[0]}, 64'd0);

      // Reset in the middle of a multiply; its result must never appear.
      send(0, MUL, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      q0.delete();
      #1;
      chk("midrst_out_valid", {63'd0, out_valid[0]}, 64'd0);
      chk("midrst_result", {32'd0, res32}, 64'd0);
      chk("midrst_zero", {63'd0, zero[0]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_midrst", {63'd0, in_ready[0]}, 64'd1);
      repeat (40) @(negedge clk);
      send(0, SLTU, 32'd3, 32'd5);

      // Random back-to-back traffic on the 8-bit instance.
      rand_ready = 1'b1;
      send(1, SRL, 32'h80, 32'd7);
      for (int k = 0; k < 9; k++) begin
         send(1, 4'(k), $urandom, $urandom);
      end
      for (int i = 0; i < 150; i++) begin
         logic [3:0]  op;
         logic [31:0] b;
         op = 4'($urandom_range(0, 11));
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         send(1, op, $urandom, b);
      end

      g = 0;
      while ((q0.size() != 0 || q1.size() != 0) && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (g >= 500) begin
         checks++;
         errors++;
         $display("FAIL drain: actual pending=%0d required pending=0", q0.size() + q1.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_alu_seq.md
SR_ALU_SEQ -- requirements
Module: sr_alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 srcA  input  WIDTH  operand A, unsigned.
REQ-008 srcB  input  WIDTH  operand B, unsigned.
REQ-009 oper  input  4  operation code (sr_alu_pkg::alu_op_t).
REQ-010 out_valid  output  1  result and zero are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered flag: result equals all-zeros.

Function
REQ-014 A request is accepted on a rising edge with in_valid and in_ready both high; operands and oper are captured then; inputs are ignored otherwise.
REQ-015 States: IDLE, BUSY, DONE; in_ready is high only in IDLE.
REQ-016 Single-cycle ops go IDLE->DONE on acceptance: ADD = A+B, SUB = A-B, OR = A|B, SRL = A >> B[SHW-1:0], SLTU = (A<B) ? 1 : 0; all mod 2^WIDTH.
REQ-017 Iterative ops go IDLE->BUSY on acceptance: MUL = low WIDTH bits of A*B; MULHU = high WIDTH bits of A*B; DIVU = A/B; REMU = A%B.
REQ-018 MUL and MULHU use a radix-2 shift-add multiplier; DIVU and REMU use a radix-2 restoring divider; the block is one shared datapath with a 2*WIDTH accumulator.
REQ-019 BUSY lasts exactly WIDTH cycles, counted by an iteration counter; BUSY->DONE on the last iteration.
REQ-020 Latency from the accepting edge to out_valid high: 1 cycle for single-cycle ops, WIDTH+1 cycles for iterative ops.
REQ-021 In DONE, out_valid is high; result and zero stay stable until out_ready is high; then DONE->IDLE on that edge.
REQ-022 in_ready returns high in the cycle after the handshake; no request overlap.
REQ-023 Divide by zero follows RISC-V: DIVU gives all-ones, REMU gives srcA; it still takes WIDTH+1 cycles.
REQ-024 Undefined oper codes behave as ADD.
REQ-025 zero is computed from the final result value, not from intermediate accumulator contents.

Reset
REQ-026 On rst assertion, at any time including mid-BUSY or in DONE: state=IDLE, out_valid=0, result=0, zero=0, iteration counter=0, accumulator=0.
REQ-027 An in-flight operation is discarded on reset and never produces out_valid.
REQ-028 in_ready is high in the first cycle after rst deasserts.

Structure
REQ-029 Package sr_alu_pkg holds:
- alu_op_t enum (4 bits): ADD=0, OR=1, SRL=2, SLTU=3, SUB=4, MUL=5, MULHU=6, DIVU=7, REMU=8
- state_t enum: IDLE, BUSY, DONE
- helper function is_iterative(alu_op_t)
REQ-030 One sub-module, sr_alu_iter_step, is combinational and computes one multiply or divide iteration from accumulator, operand and op kind; sr_alu_seq holds all registers.

Verification
REQ-031 WIDTH=32, reset, then ADD 0xFFFFFFFF+1 -> out_valid one cycle later, result=0, zero=1.
REQ-032 WIDTH=32, MUL 0x10000 x 0x10000 -> result=0, zero=1 after exactly 33 cycles; MULHU with the same operands -> result=1.
REQ-033 WIDTH=32, DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each after 33 cycles.
REQ-034 Hold out_ready low for 10 cycles after DIVU completes -> result, zero and out_valid stay stable and in_ready stays low; out_ready=1 -> in_ready high on the next cycle.
REQ-035 Assert rst at iteration 10 of a MUL -> outputs 0 immediately; the next request, SLTU 3<5, gives 1 with latency 1.
REQ-036 WIDTH=8, random back-to-back requests for all 9 ops against a reference model; check latency 1 or 9, and SRL 0x80>>7 = 1.
